imem_loader: RTL

- Writer side of the instruction-memory interface: receives a byte stream from a host/debug port and writes it as 32-bit instruction words into the writable instruction RAM that the fetch path reads by byte address.
- Assembles little-endian bytes into words and issues one write per word at word-aligned, incrementing addresses.
- Holds the processor core in reset until a load completes, so the core never fetches a partially written program.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 40 ++++
 rtl/imem_loader_packer.sv | 53 +++++
 rtl/imem_loader.sv | 135 +++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Definitions shared by the instruction-memory loader and the instruction RAM:
// the loader FSM state encoding, the word size in bytes, and the default RAM
// depth and base address. The RAM uses the same DEPTH/BASE constants, so the
// two sides agree on where the program lives.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int          WORD_BYTES          = 4;
  localparam int          WORD_COUNT_W        = 16;
  localparam int          DEFAULT_DEPTH_WORDS = 256;
  localparam logic [63:0] DEFAULT_BASE_ADDR   = 64'h0;

  // Drop a byte into lane 'lane' of a little-endian 32-bit word.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data_byte);
    logic [31:0] res;
    res = word;
    res[8*lane +: 8] = data_byte;
    return res;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Signal bundle between a host/debug port and the instruction-memory loader,
// plus the loader's write port towards the instruction RAM and its status.
//   Start/WordCount        : load request and its length in words
//   InByte/InValid/InReady : byte stream handshake (transfer = valid & ready)
//   WrEn/WrAddress/WrData  : single-cycle word write to instruction RAM
//   Busy/Done/Error        : load status
//   CoreReset              : reset hold towards the processor core
// Modports: master = host side (drives requests and bytes),
//           slave  = loader side.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 64
);

  logic                  Start;
  logic [15:0]           WordCount;
  logic [7:0]            InByte;
  logic                  InValid;
  logic                  InReady;
  logic                  WrEn;
  logic [ADDR_WIDTH-1:0] WrAddress;
  logic [31:0]           WrData;
  logic                  Busy;
  logic                  Done;
  logic                  Error;
  logic                  CoreReset;

  modport master (
    output Start, WordCount, InByte, InValid,
    input  InReady, WrEn, WrAddress, WrData, Busy, Done, Error, CoreReset
  );

  modport slave (
    input  Start, WordCount, InByte, InValid,
    output InReady, WrEn, WrAddress, WrData, Busy, Done, Error, CoreReset
  );

endinterface

// File: rtl/imem_loader_packer.sv
// ---------------------------------------------------------------------------
// imem_word_packer
// Assembles four bytes into a little-endian 32-bit word: the first byte lands
// in [7:0], the fourth in [31:24].
//   clk, rst      : clock, synchronous active-high reset (byte index only)
//   clear         : drop any partial word and restart at byte 0
//   strobe        : a byte transfers this cycle
//   data_byte     : the byte being transferred
//   word          : assembled word including the byte currently on data_byte
//   word_complete : pulses with the strobe that supplies the fourth byte
// ---------------------------------------------------------------------------
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  idx;
  logic [31:0] acc;

  // The current byte is merged combinationally so the full word is available
  // in the same cycle the fourth byte transfers.
  always_comb begin
    word          = place_byte(acc, idx, data_byte);
    word_complete = strobe && (idx == 2'd3);
  end

  // Index wraps 3 -> 0 on its own once a word completes.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= 2'd0;
    end else if (strobe) begin
      idx <= idx + 2'd1;
    end
  end

  // Every lane is rewritten before the word completes, so stale lanes left
  // by a reset never reach the output.
  always_ff @(posedge clk) begin
    if (clear) begin
      acc <= '0;
    end else if (strobe) begin
      acc <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Takes a byte stream from a host,
// packs it into little-endian 32-bit words and writes them to consecutive
// word-aligned addresses starting at BASE_ADDR. The processor core is held in
// reset (CoreReset=1) in every state but DONE, so it never runs a partially
// loaded program.
//   CLK, Reset : clock, synchronous active-high reset
//   bus        : imem_loader_if slave port (request, byte stream, RAM write,
//                status, core reset hold)
// A word takes four COLLECT cycles plus one WRITE cycle at best.
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic         CLK,
  input  logic         Reset,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0]   ADDR_STEP   = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [WORD_COUNT_W:0]   DEPTH_LIMIT = (WORD_COUNT_W+1)'(DEPTH_WORDS);

  state_t                  state;
  logic [WORD_COUNT_W-1:0] word_count;
  logic [WORD_COUNT_W-1:0] words_done;
  logic [WORD_COUNT_W-1:0] words_next;

  logic        xfer;
  logic        start_take;
  logic        start_big;
  logic        start_zero;
  logic [31:0] packed_word;
  logic        word_complete;

  // InReady is only ever 1 in COLLECT, so a transfer implies COLLECT.
  assign xfer       = bus.InValid && bus.InReady;
  assign start_take = bus.Start && ((state == ST_IDLE) || (state == ST_DONE));
  assign start_big  = {1'b0, bus.WordCount} > DEPTH_LIMIT;
  assign start_zero = (bus.WordCount == '0);
  assign words_next = words_done + 1'b1;

  imem_word_packer u_packer (
    .clk           (CLK),
    .rst           (Reset),
    .clear         (start_take),
    .strobe        (xfer),
    .data_byte     (bus.InByte),
    .word          (packed_word),
    .word_complete (word_complete)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= ST_IDLE;
      bus.WrEn      <= 1'b0;
      bus.WrAddress <= BASE_ADDR;
      bus.WrData    <= '0;
      bus.InReady   <= 1'b0;
      bus.Busy      <= 1'b0;
      bus.Done      <= 1'b0;
      bus.Error     <= 1'b0;
      bus.CoreReset <= 1'b1;
      word_count    <= '0;
      words_done    <= '0;
    end else begin
      bus.WrEn <= 1'b0;
      case (state)
        // A Start from DONE is handled exactly like one from IDLE.
        ST_IDLE, ST_DONE: begin
          if (bus.Start) begin
            if (start_big) begin
              state         <= ST_IDLE;
              bus.Error     <= 1'b1;
              bus.Done      <= 1'b0;
              bus.Busy      <= 1'b0;
              bus.InReady   <= 1'b0;
              bus.CoreReset <= 1'b1;
            end else if (start_zero) begin
              state         <= ST_DONE;
              bus.Done      <= 1'b1;
              bus.Error     <= 1'b0;
              bus.Busy      <= 1'b0;
              bus.InReady   <= 1'b0;
              bus.CoreReset <= 1'b0;
            end else begin
              state         <= ST_COLLECT;
              bus.Busy      <= 1'b1;
              bus.Done      <= 1'b0;
              bus.Error     <= 1'b0;
              bus.InReady   <= 1'b1;
              bus.CoreReset <= 1'b1;
              bus.WrAddress <= BASE_ADDR;
              word_count    <= bus.WordCount;
              words_done    <= '0;
            end
          end
        end

        ST_COLLECT: begin
          if (word_complete) begin
            state       <= ST_WRITE;
            bus.InReady <= 1'b0;
            bus.WrEn    <= 1'b1;
            bus.WrData  <= packed_word;
          end
        end

        // The write strobe is on for this single cycle; advance afterwards.
        ST_WRITE: begin
          words_done <= words_next;
          if (words_next == word_count) begin
            state         <= ST_DONE;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b1;
            bus.CoreReset <= 1'b0;
          end else begin
            state         <= ST_COLLECT;
            bus.InReady   <= 1'b1;
            bus.WrAddress <= bus.WrAddress + ADDR_STEP;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
